// File: rtl/pito_pkg.sv
// Shared pito core types and constants used by the fetch front end.
// Holds the hart count, reset PC, PC sequencer state and fetch request layout.
package pito_pkg;

  localparam int          PITO_NUM_HARTS = 8;
  localparam int          PITO_HART_W    = $clog2(PITO_NUM_HARTS);
  localparam logic [31:0] PITO_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCG_RESET = 2'd0,
    PCG_RUN   = 2'd1,
    PCG_HOLD  = 2'd2
  } pc_gen_state_e;

  typedef struct packed {
    logic [31:0]            addr;
    logic [PITO_HART_W-1:0] hart;
    logic                   epoch;
  } rv32_pc_fetch_req_t;

  // Instruction fetch is word-granular, so low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_hart_ptr.sv
// Round-robin hart pointer: 0,1,...,NUM-1,0,... advancing when adv_i is high.
// Synchronous active-high reset returns the pointer to hart 0.
module rv32_hart_ptr #(
  parameter int NUM = 8,
  parameter int W   = $clog2(NUM)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         adv_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (ptr_q == W'(NUM - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rv32_pc_gen.sv
// Per-hart PC sequencer and round-robin instruction-fetch request generator.
// Optional redirect alignment check is built when RV32_PC_ALIGN_CHECK_EN is defined.
//
// Handshake: a request is transferred on a clock edge where imem_req_valid and
// imem_req_ready are both high; while valid is high and ready is low the request
// fields are held stable, and valid never drops without a transfer (except rst).
module rv32_pc_gen
  import pito_pkg::*;
#(
  parameter int          NUM_HARTS = PITO_NUM_HARTS,
  parameter logic [31:0] RESET_PC  = PITO_RESET_PC,
  parameter int          HART_W    = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redir_valid,
  input  logic [HART_W-1:0]    redir_hart,
  input  logic [31:0]          redir_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [31:0]          imem_req_addr,
  output logic [HART_W-1:0]    imem_req_hart,
  output logic                 imem_req_epoch,
  output logic [NUM_HARTS-1:0] hart_epoch,
`ifdef RV32_PC_ALIGN_CHECK_EN
  output logic                 misalign_fault,
  output logic [31:0]          misalign_pc,
`endif
  output pc_gen_state_e        dbg_state
);

  pc_gen_state_e      state_q;
  logic [31:0]        pc_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] epoch_q;
  rv32_pc_fetch_req_t req_q;
  rv32_pc_fetch_req_t req_d;
  logic               valid_q;
  logic [HART_W-1:0]  ptr_q;
  logic [HART_W-1:0]  req_hart;
  logic               accept;
  logic               issue;
  logic               req_fresh;
  logic               redir_en;
  logic               ptr_clr;

  always_comb begin
    req_hart   = HART_W'(req_q.hart);
    accept     = (state_q == PCG_HOLD) && imem_req_ready;
    issue      = fetch_en && ((state_q == PCG_RUN) || accept);
    req_fresh  = (req_q.epoch == epoch_q[req_hart]);
    redir_en   = redir_valid && (state_q != PCG_RESET);
    ptr_clr    = rst || (state_q == PCG_RESET);
    req_d.addr  = pc_q[ptr_q];
    req_d.hart  = PITO_HART_W'(ptr_q);
    req_d.epoch = epoch_q[ptr_q];
  end

  rv32_hart_ptr #(
    .NUM (NUM_HARTS),
    .W   (HART_W)
  ) u_hart_ptr (
    .clk_i (clk),
    .rst_i (ptr_clr),
    .adv_i (issue),
    .ptr_o (ptr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PCG_RESET;
      valid_q <= 1'b0;
      req_q   <= '{addr: RESET_PC, hart: '0, epoch: 1'b0};
      epoch_q <= '0;
      for (int i = 0; i < NUM_HARTS; i++) pc_q[i] <= RESET_PC;
    end else begin
      unique case (state_q)
        PCG_RESET: begin
          for (int i = 0; i < NUM_HARTS; i++) pc_q[i] <= RESET_PC;
          epoch_q <= '0;
          state_q <= PCG_RUN;
        end
        PCG_RUN: begin
          if (fetch_en) begin
            req_q   <= req_d;
            valid_q <= 1'b1;
            state_q <= PCG_HOLD;
          end
        end
        PCG_HOLD: begin
          if (imem_req_ready) begin
            // A stale request (epoch changed since issue) must not advance the PC.
            if (req_fresh) pc_q[req_hart] <= pc_q[req_hart] + 32'd4;
            if (fetch_en) begin
              req_q <= req_d;
            end else begin
              valid_q <= 1'b0;
              state_q <= PCG_RUN;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= PCG_RESET;
        end
      endcase
      // Placed after the FSM so a same-hart redirect overrides the +4.
      if (redir_en) begin
        pc_q[redir_hart]    <= word_align(redir_pc);
        epoch_q[redir_hart] <= ~epoch_q[redir_hart];
      end
    end
  end

`ifdef RV32_PC_ALIGN_CHECK_EN
  logic        fault_q;
  logic [31:0] fault_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      fault_q <= redir_en && (redir_pc[1:0] != 2'b00);
      if (redir_en && (redir_pc[1:0] != 2'b00)) fault_pc_q <= redir_pc;
    end
  end

  assign misalign_fault = fault_q;
  assign misalign_pc    = fault_pc_q;
`endif

  assign imem_req_valid = valid_q;
  assign imem_req_addr  = req_q.addr;
  assign imem_req_hart  = req_hart;
  assign imem_req_epoch = req_q.epoch;
  assign hart_epoch     = epoch_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rv32_pc_gen.sv
// Self-checking bench for rv32_pc_gen: directed scenarios plus randomized traffic
// compared against a transaction-level model of the per-hart PCs and epochs.
module tb_rv32_pc_gen;
  import pito_pkg::*;

  localparam int N  = 8;
  localparam int HW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redir_valid = 1'b0;
  logic [HW-1:0] redir_hart = '0;
  logic [31:0]   redir_pc = 32'h0;
  logic          imem_req_ready = 1'b0;
  logic          imem_req_valid;
  logic [31:0]   imem_req_addr;
  logic [HW-1:0] imem_req_hart;
  logic          imem_req_epoch;
  logic [N-1:0]  hart_epoch;
  pc_gen_state_e dbg_state;
`ifdef RV32_PC_ALIGN_CHECK_EN
  logic          misalign_fault;
  logic [31:0]   misalign_pc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]   m_pc [N];
  logic [N-1:0]  m_epoch = '0;
  int            m_ptr = 0;
  bit            m_boot = 1'b1;
  logic          m_valid = 1'b0;
  logic [31:0]   m_addr = 32'h0;
  logic [HW-1:0] m_hart = '0;
  logic          m_ep = 1'b0;
  logic          m_fault = 1'b0;
  logic [31:0]   m_fpc = 32'h0;

  rv32_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redir_valid    (redir_valid),
    .redir_hart     (redir_hart),
    .redir_pc       (redir_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_req_hart  (imem_req_hart),
    .imem_req_epoch (imem_req_epoch),
    .hart_epoch     (hart_epoch),
`ifdef RV32_PC_ALIGN_CHECK_EN
    .misalign_fault (misalign_fault),
    .misalign_pc    (misalign_pc),
`endif
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Applies the specification's per-edge rules to the model using the inputs
  // presented for this edge.
  function automatic void model_edge();
    logic [31:0]  old_pc [N];
    logic [N-1:0] old_ep;
    bit           acc;
    if (rst) begin
      m_valid = 1'b0; m_addr = 32'h0; m_hart = '0; m_ep = 1'b0;
      m_epoch = '0; m_fault = 1'b0; m_fpc = 32'h0; m_boot = 1'b1;
      return;
    end
    if (m_boot) begin
      for (int i = 0; i < N; i++) m_pc[i] = 32'h0;
      m_epoch = '0; m_ptr = 0; m_boot = 1'b0; m_fault = 1'b0;
      return;
    end
    old_pc = m_pc;
    old_ep = m_epoch;
    acc = m_valid && imem_req_ready;
    if (acc && (m_ep == old_ep[m_hart])) m_pc[m_hart] = old_pc[m_hart] + 32'd4;
    if (fetch_en && (!m_valid || acc)) begin
      m_addr  = old_pc[m_ptr];
      m_hart  = HW'(m_ptr);
      m_ep    = old_ep[m_ptr];
      m_valid = 1'b1;
      m_ptr   = (m_ptr + 1) % N;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    m_fault = 1'b0;
    if (redir_valid) begin
      m_pc[redir_hart]    = redir_pc & 32'hFFFF_FFFC;
      m_epoch[redir_hart] = ~old_ep[redir_hart];
      if (redir_pc[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_fpc   = redir_pc;
      end
    end
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b1; imem_req_ready = 1'b1; redir_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; imem_req_ready = 1'b1; redir_valid = 1'b0;
    tick(); tick();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || imem_req_hart !== 3'd0 ||
        imem_req_epoch !== 1'b0 || hart_epoch !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b addr=%h hart=%0d ep=%b hart_epoch=%h required 0/00000000/0/0/00",
               imem_req_valid, imem_req_addr, imem_req_hart, imem_req_epoch, hart_epoch);
    end
    checks++;
    if (dbg_state !== PCG_RESET) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, PCG_RESET);
    end
`ifdef RV32_PC_ALIGN_CHECK_EN
    checks++;
    if (misalign_fault !== 1'b0 || misalign_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_fault: fault=%b pc=%h required 0/00000000", misalign_fault, misalign_pc);
    end
`endif
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req_early: valid=%b required 0 one cycle after reset", imem_req_valid);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || imem_req_hart !== 3'd0 || imem_req_epoch !== 1'b0) begin
      errors++;
      $display("FAIL first_req: valid=%b addr=%h hart=%0d ep=%b required 1/00000000/0/0",
               imem_req_valid, imem_req_addr, imem_req_hart, imem_req_epoch);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k < 16; k++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_hart !== HW'(k % N) || imem_req_addr !== 32'((k / N) * 4)) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b hart=%0d addr=%h required 1/%0d/%h",
                 k, imem_req_valid, imem_req_hart, imem_req_addr, k % N, (k / N) * 4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_hart !== 3'd3 || imem_req_addr !== 32'h0 || imem_req_epoch !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b hart=%0d addr=%h ep=%b required 1/3/00000000/0",
                 k, imem_req_valid, imem_req_hart, imem_req_addr, imem_req_epoch);
      end
    end
    imem_req_ready = 1'b1;
    tick();
    checks++;
    if (imem_req_hart !== 3'd4 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL stall_release: hart=%0d addr=%h required 4/00000000", imem_req_hart, imem_req_addr);
    end
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (imem_req_hart !== 3'd3 || imem_req_addr !== 32'h4) begin
      errors++;
      $display("FAIL stall_single_inc: hart=%0d addr=%h required 3/00000004", imem_req_hart, imem_req_addr);
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    tick(); tick(); tick();
    imem_req_ready = 1'b0;
    redir_valid = 1'b1; redir_hart = 3'd3; redir_pc = 32'h100;
    tick();
    redir_valid = 1'b0;
    checks++;
    if (hart_epoch[3] !== 1'b1 || imem_req_hart !== 3'd3 || imem_req_epoch !== 1'b0 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL redir_stale_held: hart_epoch3=%b hart=%0d ep=%b addr=%h required 1/3/0/00000000",
               hart_epoch[3], imem_req_hart, imem_req_epoch, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (imem_req_hart !== 3'd3 || imem_req_addr !== 32'h100 || imem_req_epoch !== 1'b1) begin
      errors++;
      $display("FAIL redir_target_fetch: hart=%0d addr=%h ep=%b required 3/00000100/1",
               imem_req_hart, imem_req_addr, imem_req_epoch);
    end
  endtask

  task automatic test_redirect_accept_same();
    do_reset();
    tick(); tick(); tick();
    redir_valid = 1'b1; redir_hart = 3'd3; redir_pc = 32'h200;
    tick();
    redir_valid = 1'b0;
    checks++;
    if (hart_epoch !== 8'h08) begin
      errors++;
      $display("FAIL redir_accept_epoch: hart_epoch=%h required 08", hart_epoch);
    end
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (imem_req_hart !== 3'd3 || imem_req_addr !== 32'h200 || imem_req_epoch !== 1'b1) begin
      errors++;
      $display("FAIL redir_accept_wins: hart=%0d addr=%h ep=%b required 3/00000200/1",
               imem_req_hart, imem_req_addr, imem_req_epoch);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b0;
    redir_valid = 1'b1; redir_hart = 3'd5; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    imem_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (imem_req_hart !== 3'd5 || imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pre: hart=%0d addr=%h required 5/fffffffc", imem_req_hart, imem_req_addr);
    end
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (imem_req_hart !== 3'd5 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_post: hart=%0d addr=%h required 5/00000000", imem_req_hart, imem_req_addr);
    end
  endtask

`ifdef RV32_PC_ALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    imem_req_ready = 1'b0;
    redir_valid = 1'b1; redir_hart = 3'd2; redir_pc = 32'h102;
    tick();
    redir_valid = 1'b0;
    checks++;
    if (misalign_fault !== 1'b1 || misalign_pc !== 32'h102) begin
      errors++;
      $display("FAIL misalign_pulse: fault=%b pc=%h required 1/00000102", misalign_fault, misalign_pc);
    end
    tick();
    checks++;
    if (misalign_fault !== 1'b0) begin
      errors++;
      $display("FAIL misalign_one_cycle: fault=%b required 0", misalign_fault);
    end
    imem_req_ready = 1'b1;
    tick(); tick();
    checks++;
    if (imem_req_hart !== 3'd2 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL misalign_fetch: hart=%0d addr=%h required 2/00000100", imem_req_hart, imem_req_addr);
    end
  endtask
`endif

  task automatic test_rst_hold();
    do_reset();
    imem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || dbg_state !== PCG_RESET) begin
      errors++;
      $display("FAIL rst_hold_drop: valid=%b state=%0d required 0/%0d", imem_req_valid, dbg_state, PCG_RESET);
    end
    rst = 1'b0;
    imem_req_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_random();
    int ok_v, ok_a, ok_h, ok_e, ok_ep;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 199) == 0);
      redir_valid    = ($urandom_range(0, 5) == 0);
      redir_hart     = HW'($urandom_range(0, N - 1));
      redir_pc       = $urandom();
      tick();
      ok_v  = (imem_req_valid === m_valid);
      ok_a  = (imem_req_addr  === m_addr);
      ok_h  = (imem_req_hart  === m_hart);
      ok_e  = (imem_req_epoch === m_ep);
      ok_ep = (hart_epoch     === m_epoch);
      checks++;
      if (!(ok_v && ok_a && ok_h && ok_e && ok_ep)) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b a=%h h=%0d e=%b he=%h required v=%b a=%h h=%0d e=%b he=%h",
                 c, imem_req_valid, imem_req_addr, imem_req_hart, imem_req_epoch, hart_epoch,
                 m_valid, m_addr, m_hart, m_ep, m_epoch);
      end
`ifdef RV32_PC_ALIGN_CHECK_EN
      checks++;
      if (misalign_fault !== m_fault || misalign_pc !== m_fpc) begin
        errors++;
        $display("FAIL random_fault[%0d]: got %b/%h required %b/%h",
                 c, misalign_fault, misalign_pc, m_fault, m_fpc);
      end
`endif
    end
    rst = 1'b0; redir_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_accept_same();
    test_wrap();
`ifdef RV32_PC_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_rst_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_pc_gen.md
# rv32_pc_gen

Per-hart program-counter sequencer and instruction-fetch request generator for the pito barrel core. Holds one PC per hart and walks the harts round-robin, issuing one fetch request per cycle to instruction memory under a valid/ready handshake. It is the consumer of the redirect interface driven by `rv32_next_pc`: `has_new_pc`, `next_pc_val` and the hart tag. Each accepted redirect overwrites the hart's PC and toggles a per-hart epoch bit, so downstream stages can drop instructions that were already in flight when the redirect arrived.

## Interface
- `NUM_HARTS`, 8: number of harts; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC value loaded into every hart at reset.
- `HART_W`, $clog2(NUM_HARTS): width of the hart id.
- Clocking: one clock, `clk`. Reset `rst` is synchronous and active-high.
- `clk` in 1: core clock.
- `rst` in 1: synchronous active-high reset.
- `fetch_en` in 1: global fetch enable. When 0, no new request is issued.
- `redir_valid` in 1: redirect strobe, driven from `rv32_has_new_pc`.
- `redir_hart` in HART_W: hart that owns the redirect.
- `redir_pc` in 32: redirect target, driven from `rv32_next_pc_val`.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: instruction memory accepts the request.
- `imem_req_addr` out 32: fetch byte address.
- `imem_req_hart` out HART_W: hart tag for the request.
- `imem_req_epoch` out 1: the hart's epoch at the moment the request was issued.
- `hart_epoch` out NUM_HARTS: current epoch of each hart, for stale-instruction compare downstream.
- `misalign_fault` out 1: one-cycle pulse on a misaligned redirect. Present only with `RV32_PC_ALIGN_CHECK_EN`.
- `misalign_pc` out 32: the offending target. Present only with `RV32_PC_ALIGN_CHECK_EN`.

## Operation
- State: `pc_q[NUM_HARTS]`, `epoch_q[NUM_HARTS]`, hart pointer `ptr_q`, request register, and FSM `{RESET, RUN, HOLD}`.
- RESET:
  - Occupied for the one cycle after `rst` deasserts.
  - On that cycle: every `pc_q` = RESET_PC, every `epoch_q` = 0, `ptr_q` = 0.
  - Then go to RUN.
- RUN (request slot free):
  - If `fetch_en` = 1: load the request register with {addr = `pc_q[ptr_q]`, hart = `ptr_q`, epoch = `epoch_q[ptr_q]`}.
  - In the same cycle: set `ptr_q` = `ptr_q`+1, wrapping NUM_HARTS-1 → 0, and go to HOLD.
  - If `fetch_en` = 0: stay in RUN with `imem_req_valid` = 0.
- HOLD (request outstanding): `imem_req_valid` = 1 and all request fields stay stable until `imem_req_ready`.
  - On accept, if the request's epoch equals `epoch_q[hart]`: `pc_q[hart]` += 4.
  - On accept, if the request is stale (epochs differ): PC is not incremented.
  - On accept with `fetch_en` = 1: issue the next request in the same cycle (back-to-back) and stay in HOLD.
  - On accept with `fetch_en` = 0: go to RUN.
- Redirect (any state except RESET): `pc_q[redir_hart]` = {`redir_pc`[31:2], 2'b00} and `epoch_q[redir_hart]` toggles.
- An outstanding request is never modified by a redirect. It simply becomes stale by epoch mismatch.
- Simultaneous redirect and accept for the same hart: the redirect wins. PC = target, no +4.
- A request issued in the same cycle as a redirect to that hart uses the pre-redirect PC and the pre-toggle epoch, so it is stale.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 → 0.
- `rst` during HOLD: the request is dropped immediately (`imem_req_valid` = 0 on the next edge) and the FSM goes to RESET.

## Timing
- Reset values of outputs:
  - `imem_req_valid` = 0, `imem_req_addr` = RESET_PC, `imem_req_hart` = 0, `imem_req_epoch` = 0.
  - `hart_epoch` = 0.
  - `misalign_fault` = 0, `misalign_pc` = 0.
- All outputs are registered.
- First request (hart 0, RESET_PC) is valid 2 cycles after `rst` deasserts, given `fetch_en` = 1.
- Sustained throughput is 1 request per cycle with `imem_req_ready` held high. The hart sequence is 0,1,…,N-1,0…
- A redirect takes effect in `pc_q` and `hart_epoch` on the next edge. The earliest fetch of the target is that hart's next round-robin slot.

## Configuration
- `RV32_PC_ALIGN_CHECK_EN` defined:
  - A redirect with `redir_pc[1:0]` ≠ 0 pulses `misalign_fault` for 1 cycle, with `misalign_pc` = `redir_pc`.
  - The PC is still loaded, truncated to word alignment.
- `RV32_PC_ALIGN_CHECK_EN` undefined:
  - Both fault ports and the check logic are absent.
  - Targets are silently truncated to word alignment.

## Structure
- `pito_pkg` gains `pc_gen_state_e` {RESET, RUN, HOLD}, `rv32_pc_fetch_req_t` {addr, hart, epoch}, and `PITO_RESET_PC`.
- `NUM_HARTS` is taken from the existing `pito_pkg` hart-count constant.
- One sub-module, `rv32_hart_ptr`: a round-robin counter with an advance enable and synchronous reset.

## Test plan
- Reset, then `fetch_en` = 1, ready = 1 → addrs 0,0,…(harts 0..7) then 4,4,… (harts 0..7). First valid 2 cycles after reset.
- Ready = 0 for 3 cycles mid-stream → addr, hart and epoch are held stable. No PC increments until the accept.
- Redirect hart 3 → 32'h100 while hart 3's request is outstanding:
  - The request is accepted with epoch 0 while `hart_epoch[3]` = 1, i.e. stale.
  - Hart 3's next fetch is 32'h100.
- Redirect and accept for the same hart in the same cycle → PC = target (not target+4), epoch toggled.
- PC 32'hFFFF_FFFC accepted → next fetch for that hart is 32'h0.
- With `RV32_PC_ALIGN_CHECK_EN`:
  - Redirect to 32'h102 → `misalign_fault` pulses 1 cycle with `misalign_pc` = 32'h102, and the next fetch is 32'h100.
  - `rst` asserted mid-HOLD → valid drops on the next edge.
